// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and the burst next-address rule used by the read engine.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // WRAP assumes a legal power-of-two container; illegal wraps are flagged SLVERR upstream.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] b;
    logic [31:0] w;
    b = 32'd1 << size;
    w = (32'(len) + 32'd1) << size;
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~(w - 32'd1)) | ((a + b) & (w - 32'd1));
      default:     next_addr = a + b;
    endcase
  endfunction

endpackage

// File: rtl/axi_skid_fifo.sv
// Two-entry FIFO holding complete R beats; absorbs rready backpressure.
module axi_skid_fifo #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign full      = (cnt == 2'd2);
  assign empty     = (cnt == 2'd0);
  assign out_valid = !empty;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = slot[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= in_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_slave_read_engine.sv
// AXI3 read slave: accepts one AR burst at a time, reads a 1-cycle SRAM and returns R beats.
module axi_slave_read_engine
  import axi_pkg::*;
#(
  parameter int          ID_W     = 4,
  parameter int          MEM_AW   = 10,
  parameter logic [31:0] MEM_BASE = 32'h0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);
  localparam int ENTRY_W = ID_W + 32 + 2 + 1;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e            state;
  logic [ID_W-1:0]   lat_id;
  logic [31:0]       addr;
  logic [3:0]        len;
  logic [3:0]        beat_cnt;
  logic [2:0]        size;
  logic [1:0]        burst;
  logic              slverr;
  logic              issue_done;
  logic              inflight;
  logic [1:0]        inflight_resp;
  logic              inflight_last;
  logic              issue;
  logic              pop;
  logic              ar_hs;
  logic [2:0]        queued;
  logic [2:0]        occ;
  logic [1:0]        beat_resp;
  logic [31:0]       offset;
  logic              fifo_in_ready;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       push_data;
  logic [ENTRY_W-1:0] fifo_out;

  function automatic logic burst_illegal(input logic [2:0] s, input logic [1:0] b,
                                         input logic [3:0] l);
    return (s > 3'd2) || (b == BURST_RSVD) ||
           ((b == BURST_WRAP) && !(l inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  // SLVERR covers the whole burst and outranks the per-beat range check.
  function automatic logic [1:0] resp_for(input logic slv, input logic [31:0] a);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, MEM_BASE};
    hi = lo + (33'd4 << MEM_AW);
    if (slv) return RESP_SLVERR;
    if (({1'b0, a} < lo) || ({1'b0, a} >= hi)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  assign ar_hs     = (state == S_IDLE) && arvalid && arready;
  assign pop       = rvalid && rready;
  assign queued    = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
  assign occ       = queued + {2'b0, inflight} - {2'b0, pop};
  assign beat_resp = resp_for(slverr, addr);
  assign issue     = (state == S_BURST) && !issue_done && (occ < 3'd2) && fifo_in_ready;
  assign offset    = addr - MEM_BASE;
  assign mem_addr  = MEM_AW'(offset >> 2);
  assign mem_en    = issue && (beat_resp == RESP_OKAY);
  assign push_data = (inflight_resp == RESP_OKAY) ? mem_rdata : 32'd0;

  // Control: FSM, beat counter, in-flight flag
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= S_IDLE;
      arready    <= 1'b0;
      beat_cnt   <= 4'd0;
      issue_done <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        S_IDLE: begin
          arready <= 1'b1;
          if (ar_hs) begin
            state      <= S_BURST;
            arready    <= 1'b0;
            beat_cnt   <= 4'd0;
            issue_done <= 1'b0;
          end
        end
        S_BURST: begin
          if (issue) begin
            beat_cnt   <= beat_cnt + 4'd1;
            issue_done <= (beat_cnt == len);
          end
          if (pop && rlast) begin
            state   <= S_IDLE;
            arready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: latched request, address walk, in-flight beat attributes
  always_ff @(posedge aclk) begin
    if (ar_hs) begin
      lat_id <= arid;
      addr   <= araddr;
      len    <= arlen;
      size   <= arsize;
      burst  <= arburst;
      slverr <= burst_illegal(arsize, arburst, arlen);
    end else if (issue) begin
      addr <= next_addr(addr, size, len, burst);
    end
    if (issue) begin
      inflight_resp <= beat_resp;
      inflight_last <= (beat_cnt == len);
    end
  end

  axi_skid_fifo #(.W(ENTRY_W)) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .in_valid  (inflight),
    .in_ready  (fifo_in_ready),
    .in_data   ({lat_id, push_data, inflight_resp, inflight_last}),
    .out_valid (rvalid),
    .out_ready (rready),
    .out_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {rid, rdata, rresp, rlast} = fifo_out;

endmodule

// File: tb/tb_axi_slave_read_engine.sv
// Directed and randomized bench for axi_slave_read_engine with an arithmetic burst model.
module tb_axi_slave_read_engine;
  localparam int          ID_W     = 4;
  localparam int          MEM_AW   = 10;
  localparam logic [31:0] MEM_BASE = 32'h0;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } req_t;

  logic              aclk;
  logic              areset;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [3:0]  wrap_lens [4] = '{4'd1, 4'd3, 4'd7, 4'd15};
  int checks = 0;
  int errors = 0;

  axi_slave_read_engine #(.ID_W(ID_W), .MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE)) dut (
    .aclk(aclk), .areset(areset), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) if (mem_en) mem_rdata <= mem[mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input int id, input logic [31:0] a, input int l,
                              input int s, input int b);
    req_t r;
    r.id = ID_W'(id); r.addr = a; r.len = 4'(l); r.size = 3'(s); r.burst = 2'(b);
    return r;
  endfunction

  // Starts and ends at a sample point (2 time units after a rising edge).
  task automatic run_burst(input req_t r, input req_t nxt, input bit rand_ready,
                           input bit timing, input bit hold);
    logic [31:0]       e_data [$];
    logic [1:0]        e_resp [$];
    logic [MEM_AW-1:0] e_waddr [$];
    bit     slv;
    longint bb, ww, a0, ai, lo, hi;
    int     cyc, beats, issued, w;
    bit     done, hs, prev_stall;
    logic [39:0] prev_vec;

    slv = (r.size > 3'd2) || (r.burst == 2'd3) ||
          (r.burst == 2'd2 && !(r.len == 4'd1 || r.len == 4'd3 || r.len == 4'd7 || r.len == 4'd15));
    bb = longint'(1) << r.size;
    ww = (longint'(r.len) + 1) * bb;
    a0 = longint'(r.addr);
    lo = longint'(MEM_BASE);
    hi = lo + 4 * (longint'(1) << MEM_AW);
    for (int i = 0; i <= int'(r.len); i++) begin
      case (r.burst)
        2'd1:    ai = (a0 + i * bb) % 64'h1_0000_0000;
        2'd2:    ai = (a0 / ww) * ww + ((a0 % ww) + i * bb) % ww;
        default: ai = a0;
      endcase
      if (slv) begin
        e_resp.push_back(2'b10); e_data.push_back(32'd0);
      end else if (ai < lo || ai >= hi) begin
        e_resp.push_back(2'b11); e_data.push_back(32'd0);
      end else begin
        e_resp.push_back(2'b00);
        e_data.push_back(mem[int'((ai - lo) / 4)]);
        e_waddr.push_back(MEM_AW'((ai - lo) / 4));
      end
    end

    arid = r.id; araddr = r.addr; arlen = r.len; arsize = r.size; arburst = r.burst;
    arvalid = 1'b1;
    w = 0;
    while (!arready && w < 50) begin
      @(posedge aclk); #2; w++;
    end
    if (!arready) begin
      check("ar_accept_timeout", {63'd0, arready}, 64'd1);
      arvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    cyc = 0; beats = 0; issued = 0; done = 0; prev_stall = 0; prev_vec = '0;
    while (!done && cyc < 300) begin
      #1;
      arvalid = hold;
      if (hold) begin
        arid = nxt.id; araddr = nxt.addr; arlen = nxt.len; arsize = nxt.size; arburst = nxt.burst;
      end
      rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      hs = rvalid && rready;
      if (prev_stall) check("r_stable", {24'd0, rvalid, rid, rdata, rresp, rlast}, {24'd0, prev_vec});
      if (hold) check("ar_blocked_in_burst", {63'd0, arready}, 64'd0);
      if (mem_en) begin
        check("mem_credit", {63'd0, (issued - beats - int'(hs)) < 2}, 64'd1);
        if (issued < e_waddr.size()) check("mem_addr", {54'd0, mem_addr}, {54'd0, e_waddr[issued]});
        else check("mem_en_extra", 64'(issued), 64'(e_waddr.size()));
        issued++;
      end
      if (hs) begin
        check("rid", {60'd0, rid}, {60'd0, r.id});
        check("rdata", {32'd0, rdata}, {32'd0, e_data[beats]});
        check("rresp", {62'd0, rresp}, {62'd0, e_resp[beats]});
        check("rlast", {63'd0, rlast}, {63'd0, beats == int'(r.len)});
        if (timing && beats == 0) check("first_rvalid_latency", 64'(cyc), 64'd2);
        if (timing && beats == int'(r.len)) check("last_beat_cycle", 64'(cyc), 64'(int'(r.len) + 2));
        beats++;
        if (beats == int'(r.len) + 1) done = 1;
      end
      prev_stall = rvalid && !rready;
      prev_vec   = {rvalid, rid, rdata, rresp, rlast};
      @(posedge aclk);
      cyc++;
    end
    if (!done) check("burst_timeout_beats", 64'(beats), 64'(int'(r.len) + 1));
    #2;
    check("mem_en_count", 64'(issued), 64'(e_waddr.size()));
    check("back_to_idle_arready", {63'd0, arready}, 64'd1);
    check("r_drained", {63'd0, rvalid}, 64'd0);
  endtask

  initial begin
    req_t r, z;
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'hA000_0000 + i;
    z = mk(0, 32'h0, 0, 2, 1);
    areset = 1'b1; arvalid = 1'b0; rready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_arready", {63'd0, arready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_r_fields", {24'd0, rid, rdata, rresp, rlast}, 64'd0);
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    areset = 1'b0;
    @(posedge aclk); #2;
    check("post_rst_arready", {63'd0, arready}, 64'd1);

    // Basic INCR, WRAP, FIXED
    run_burst(mk(5, 32'h10, 3, 2, 1), z, 0, 1, 0);
    run_burst(mk(1, 32'h38, 3, 2, 2), z, 0, 1, 0);
    run_burst(mk(7, 32'h20, 2, 2, 0), z, 0, 1, 0);
    // Full-length burst: throughput and latency
    run_burst(mk(9, 32'h100, 15, 2, 1), z, 0, 1, 0);
    // Backpressure
    run_burst(mk(3, 32'h200, 15, 2, 1), z, 1, 0, 0);
    // Error responses
    run_burst(mk(4, 32'd4 << MEM_AW, 1, 2, 1), z, 0, 1, 0);
    run_burst(mk(6, 32'h40, 2, 2, 3), z, 0, 1, 0);
    run_burst(mk(8, 32'h40, 1, 3, 1), z, 1, 0, 0);
    run_burst(mk(10, 32'h40, 2, 2, 2), z, 0, 1, 0);
    run_burst(mk(11, (32'd4 << MEM_AW) - 32'd8, 3, 2, 1), z, 1, 0, 0);

    // Reset in the middle of a stalled burst
    arid = 4'd3; araddr = 32'h40; arlen = 4'd7; arsize = 3'd2; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b0;
    check("mid_rst_pre_arready", {63'd0, arready}, 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    check("mid_rst_queued_rvalid", {63'd0, rvalid}, 64'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("mid_rst_arready", {63'd0, arready}, 64'd0);
    check("mid_rst_mem_en", {63'd0, mem_en}, 64'd0);
    areset = 1'b0;
    @(posedge aclk); #2;
    check("mid_rst_idle_arready", {63'd0, arready}, 64'd1);
    check("mid_rst_no_stale", {63'd0, rvalid}, 64'd0);
    run_burst(mk(2, 32'h80, 3, 2, 1), z, 0, 1, 0);

    // Back-to-back with arvalid held through the first burst
    r = mk(13, 32'h300, 4, 2, 1);
    run_burst(mk(12, 32'h280, 2, 2, 1), r, 0, 1, 1);
    run_burst(r, z, 0, 1, 0);

    // Randomized legal and out-of-range bursts
    for (int k = 0; k < 10; k++) begin
      r.id    = ID_W'($urandom_range(0, 15));
      r.size  = 3'($urandom_range(0, 2));
      r.burst = 2'($urandom_range(0, 2));
      r.len   = (r.burst == 2'd2) ? wrap_lens[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
      r.addr  = 32'($urandom_range(0, (4 << MEM_AW) + 64));
      run_burst(r, z, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
